// File: rtl/agc_timepulse_gen.sv
// agc_timepulse_gen: master-clock divider producing the free-running scaler
// drive FS01_, the active-low time-pulse ring T01..T(NUM_TP) with phase strobes
// PHS2_/PHS4_, and the once-per-memory-cycle MCT pulse. The ring can be
// held at the end of a memory cycle (monitor stop) and single-stepped.
module agc_timepulse_gen #(
    parameter int FS01_HALF   = 20,
    parameter int PHASE_COUNT = 2,
    parameter int NUM_TP      = 12
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              MSTP,
    input  logic              MSTRT,
    output logic              FS01_,
    output logic [NUM_TP-1:0] T_,
    output logic              PHS2_,
    output logic              PHS4_,
    output logic              MCT,
    output logic              STOPPED
);

    localparam int PW = (FS01_HALF > 1) ? $clog2(FS01_HALF) : 1;
    localparam int SW = (PHASE_COUNT > 1) ? $clog2(PHASE_COUNT) : 1;
    localparam int TW = $clog2(NUM_TP + 1);

    localparam logic [PW-1:0] PLAST = PW'(FS01_HALF - 1);
    localparam logic [SW-1:0] SLAST = SW'(PHASE_COUNT - 1);
    localparam logic [TW-1:0] TLAST = TW'(NUM_TP);
    localparam logic [TW-1:0] TFIRST = TW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [PW-1:0] pcnt;
    logic [1:0]    state, nstate;
    logic [TW-1:0] tp, ntp;
    logic [SW-1:0] sub, nsub;
    logic          mstrt_q;
    logic          mstrt_rise;
    logic          nrun;
    logic [NUM_TP-1:0] t_nxt;

    assign mstrt_rise = MSTRT & ~mstrt_q;

    // Prescaler: free-running FS01_ divider, never affected by the ring state.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            pcnt  <= '0;
            FS01_ <= 1'b1;
        end else if (pcnt == PLAST) begin
            pcnt  <= '0;
            FS01_ <= ~FS01_;
        end else begin
            pcnt  <= pcnt + 1'b1;
        end
    end

    // MSTRT history for edge detection; sampled every clock so a level held
    // through a run cannot register as a fresh edge when HOLD is re-entered.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) mstrt_q <= 1'b0;
        else     mstrt_q <= MSTRT;
    end

    // Ring sequencing: stop requests only take effect at the end of the last
    // time pulse so a memory cycle is never cut short.
    always_comb begin
        nstate = state;
        ntp    = tp;
        nsub   = sub;
        case (state)
            IDLE: begin
                nstate = RUN;
                ntp    = TFIRST;
                nsub   = '0;
            end
            RUN: begin
                if (sub == SLAST) begin
                    nsub = '0;
                    if (tp == TLAST) begin
                        ntp = TFIRST;
                        if (MSTP) nstate = HOLD;
                    end else begin
                        ntp = tp + 1'b1;
                    end
                end else begin
                    nsub = sub + 1'b1;
                end
            end
            HOLD: begin
                if (!MSTP || mstrt_rise) begin
                    nstate = RUN;
                    ntp    = TFIRST;
                    nsub   = '0;
                end
            end
            default: begin
                nstate = IDLE;
                ntp    = TFIRST;
                nsub   = '0;
            end
        endcase
    end

    // One-hot active-low decode of the next time pulse.
    always_comb begin
        nrun  = (nstate == RUN);
        t_nxt = '1;
        for (int i = 0; i < NUM_TP; i++)
            t_nxt[i] = ~(nrun && (ntp == TW'(i + 1)));
    end

    // State and registered outputs, all derived from the next state so the
    // outputs line up with the state they describe.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tp      <= TFIRST;
            sub     <= '0;
            T_      <= '1;
            PHS2_   <= 1'b1;
            PHS4_   <= 1'b1;
            MCT     <= 1'b0;
            STOPPED <= 1'b0;
        end else begin
            state   <= nstate;
            tp      <= ntp;
            sub     <= nsub;
            T_      <= t_nxt;
            PHS2_   <= ~(nrun && (nsub == '0));
            PHS4_   <= ~(nrun && (nsub == SLAST));
            MCT     <= nrun && (ntp == TLAST) && (nsub == SLAST);
            STOPPED <= (nstate == HOLD);
        end
    end

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Bench for agc_timepulse_gen: two instances (PHASE_COUNT 2 and 4) share the
// same stimulus and are compared every clock against a position-counter model
// of the memory cycle, plus a table of fixed checkpoints after reset release.
module tb_agc_timepulse_gen;

    localparam int FH = 20;
    localparam int NT = 12;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic CLOCK = 1'b0;
    logic rst, MSTP, MSTRT;
    logic fs_a, phs2_a, phs4_a, mct_a, stp_a;
    logic fs_b, phs2_b, phs4_b, mct_b, stp_b;
    logic [NT-1:0] t_a, t_b;

    always #5 CLOCK = ~CLOCK;

    agc_timepulse_gen #(.FS01_HALF(FH), .PHASE_COUNT(2), .NUM_TP(NT)) dut_a (
        .CLOCK(CLOCK), .rst(rst), .MSTP(MSTP), .MSTRT(MSTRT),
        .FS01_(fs_a), .T_(t_a), .PHS2_(phs2_a), .PHS4_(phs4_a),
        .MCT(mct_a), .STOPPED(stp_a));

    agc_timepulse_gen #(.FS01_HALF(FH), .PHASE_COUNT(4), .NUM_TP(NT)) dut_b (
        .CLOCK(CLOCK), .rst(rst), .MSTP(MSTP), .MSTRT(MSTRT),
        .FS01_(fs_b), .T_(t_b), .PHS2_(phs2_b), .PHS4_(phs4_b),
        .MCT(mct_b), .STOPPED(stp_b));

    // Model: position within the memory cycle, 0 .. NT*pc-1.
    typedef struct {
        int mode;
        int pos;
    } ring_t;

    typedef struct {
        int         edge_no;
        logic [11:0] t;
        logic       phs2;
        logic       phs4;
        logic       mct;
        logic       fs;
    } vec_t;

    int    vecs = 0;
    int    errs = 0;
    int    n;
    bit    mprev;
    ring_t ra, rb;

    function automatic ring_t ring_next(ring_t r, int pc, bit mstp, bit rise);
        ring_t q = r;
        int len = NT * pc;
        case (r.mode)
            M_IDLE: begin q.mode = M_RUN; q.pos = 0; end
            M_RUN: begin
                if (r.pos == len - 1) begin
                    q.pos = 0;
                    if (mstp) q.mode = M_HOLD;
                end else q.pos = r.pos + 1;
            end
            default: if (!mstp || rise) begin q.mode = M_RUN; q.pos = 0; end
        endcase
        return q;
    endfunction

    function automatic logic [NT-1:0] exp_t(ring_t r, int pc);
        logic [NT-1:0] v = '1;
        if (r.mode == M_RUN) v[r.pos / pc] = 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        n = 0; mprev = 0;
        ra.mode = M_IDLE; ra.pos = 0;
        rb.mode = M_IDLE; rb.pos = 0;
    endtask

    task automatic model_edge();
        bit rise;
        if (rst) model_reset();
        else begin
            rise  = MSTRT && !mprev;
            mprev = MSTRT;
            n++;
            ra = ring_next(ra, 2, MSTP, rise);
            rb = ring_next(rb, 4, MSTP, rise);
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_one(string tag, ring_t r, int pc, logic fs, logic [NT-1:0] t,
                             logic p2, logic p4, logic m, logic s);
        bit run = (r.mode == M_RUN);
        check({tag, "_fs01"},  32'(fs), 32'(((n / FH) % 2) == 0));
        check({tag, "_t"},     32'(t),  32'(exp_t(r, pc)));
        check({tag, "_phs2"},  32'(p2), 32'(!(run && (r.pos % pc) == 0)));
        check({tag, "_phs4"},  32'(p4), 32'(!(run && (r.pos % pc) == pc - 1)));
        check({tag, "_mct"},   32'(m),  32'(run && r.pos == NT * pc - 1));
        check({tag, "_stop"},  32'(s),  32'(r.mode == M_HOLD));
    endtask

    task automatic check_all();
        check_one("a", ra, 2, fs_a, t_a, phs2_a, phs4_a, mct_a, stp_a);
        check_one("b", rb, 4, fs_b, t_b, phs2_b, phs4_b, mct_b, stp_b);
    endtask

    task automatic step();
        @(posedge CLOCK);
        model_edge();
        #1 check_all();
    endtask

    task automatic wait_hold(string name);
        int k = 0;
        while (!(ra.mode == M_HOLD && rb.mode == M_HOLD) && k < 200) begin
            step(); k++;
        end
        check({name, "_hold_timeout"}, 32'(k < 200), 32'(1));
    endtask

    initial begin
        vec_t tbl [12];
        int   e, ca, cb, k;

        tbl[0]  = '{1,  12'hFFE, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{2,  12'hFFE, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{3,  12'hFFD, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{19, 12'hDFF, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{20, 12'hDFF, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{23, 12'h7FF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{24, 12'h7FF, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{25, 12'hFFE, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{40, 12'hF7F, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{48, 12'h7FF, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{60, 12'hFDF, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{72, 12'h7FF, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        rst = 1'b1; MSTP = 1'b0; MSTRT = 1'b0;
        model_reset();
        repeat (3) step();
        #2 rst = 1'b0;

        // Free run after release: fixed checkpoints plus per-clock model
        e = 0;
        for (int i = 0; i < 12; i++) begin
            while (e < tbl[i].edge_no) begin step(); e++; end
            check($sformatf("tbl%0d_t", i),    32'(t_a),    32'(tbl[i].t));
            check($sformatf("tbl%0d_phs2", i), 32'(phs2_a), 32'(tbl[i].phs2));
            check($sformatf("tbl%0d_phs4", i), 32'(phs4_a), 32'(tbl[i].phs4));
            check($sformatf("tbl%0d_mct", i),  32'(mct_a),  32'(tbl[i].mct));
            check($sformatf("tbl%0d_fs01", i), 32'(fs_a),   32'(tbl[i].fs));
        end
        repeat (48) step();

        // MSTP raised in the middle of T05: cycle completes, then hold
        k = 0;
        while (!(ra.mode == M_RUN && ra.pos == 9) && k < 100) begin step(); k++; end
        check("t05_timeout", 32'(k < 100), 32'(1));
        MSTP = 1'b1;
        ca = 0; k = 0;
        while (ra.mode != M_HOLD && k < 100) begin step(); k++; if (mct_a) ca++; end
        check("mct_before_hold", 32'(ca), 32'(1));
        wait_hold("stop");
        check("hold_t", 32'(t_a), 32'(12'hFFF));
        check("hold_stopped", 32'(stp_a), 32'(1));
        repeat (80) step();

        // Three single steps
        ca = 0; cb = 0;
        for (int p = 0; p < 3; p++) begin
            MSTRT = 1'b1; step(); MSTRT = 1'b0;
            if (mct_a) ca++;
            if (mct_b) cb++;
            repeat (59) begin step(); if (mct_a) ca++; if (mct_b) cb++; end
        end
        check("step3_mct_a", 32'(ca), 32'(3));
        check("step3_mct_b", 32'(cb), 32'(3));
        check("step3_stopped", 32'(stp_a), 32'(1));

        // MSTRT held high yields a single step
        ca = 0; cb = 0;
        MSTRT = 1'b1;
        repeat (100) begin step(); if (mct_a) ca++; if (mct_b) cb++; end
        check("held_mct_a", 32'(ca), 32'(1));
        check("held_mct_b", 32'(cb), 32'(1));
        MSTRT = 1'b0;
        repeat (5) step();

        // Drop MSTP in hold: resume on the next edge
        MSTP = 1'b0; step();
        check("resume_t", 32'(t_a), 32'(12'hFFE));
        check("resume_stopped", 32'(stp_a), 32'(0));
        repeat (60) step();

        // MSTP drop together with an MSTRT edge: one resume only
        MSTP = 1'b1;
        wait_hold("stop2");
        MSTP = 1'b0; MSTRT = 1'b1; step();
        check("both_t", 32'(t_b), 32'(12'hFFE));
        check("both_stopped", 32'(stp_b), 32'(0));
        MSTRT = 1'b0;
        repeat (100) step();

        // Randomized MSTP/MSTRT against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) MSTP = ~MSTP;
            MSTRT = ($urandom_range(0, 3) == 0);
            step();
        end

        // Asynchronous reset in the middle of T08
        MSTP = 1'b0; MSTRT = 1'b0;
        k = 0;
        while (!(ra.mode == M_RUN && ra.pos == 14) && k < 200) begin step(); k++; end
        check("t08_timeout", 32'(k < 200), 32'(1));
        #3 rst = 1'b1;
        #1 model_reset();
        check("arst_t", 32'(t_a), 32'(12'hFFF));
        check("arst_mct", 32'(mct_a), 32'(0));
        check_all();
        repeat (2) step();
        #2 rst = 1'b0;
        step();
        check("rel_t01", 32'(t_a), 32'(12'hFFE));
        repeat (18) step();
        check("rel_fs01_19", 32'(fs_a), 32'(1));
        step();
        check("rel_fs01_20", 32'(fs_a), 32'(0));
        repeat (60) step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
